// File: rtl/crc32_fcs_append_pkg.sv
// Shared definitions for the transmit FCS appender: FSM state encoding and
// the common reflected CRC polynomials.
package crc32_fcs_append_pkg;

    // Sequencer states: wait for a byte, shift its 8 bits into the CRC,
    // or emit the complemented CRC bytes.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FCS   = 2'd2
    } state_t;

    // Reflected (LSB-first) polynomials.
    localparam logic [31:0] CRC32_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC32C_POLY = 32'h82F63B78;

endpackage

// File: rtl/crc32_fcs_append_crc_serial.sv
// Bit-serial reflected CRC register. Each enabled cycle it absorbs one data
// bit; the register sits at all-ones while reset is high.
module crc_serial #(
    parameter int             W = 32,
    parameter logic [W-1:0]   P = W'(32'hEDB88320)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;
    logic         w_fb;

    // Feedback is the outgoing LSB mixed with the incoming data bit.
    assign w_fb = r_q[0] ^ d;

    // One LFSR step per enabled cycle; all-ones preset on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '1;
        end else if (enable) begin
            r_q <= (r_q >> 1) ^ (w_fb ? P : '0);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/crc32_fcs_append.sv
// Transmit-path FCS appender. Payload bytes pass straight through a
// single-entry output register while their bits are fed LSB-first into a
// serial CRC; after the last payload byte the complemented CRC follows as
// W/8 bytes, least-significant byte first.
module crc32_fcs_append
    import crc32_fcs_append_pkg::*;
#(
    parameter int           W = 32,
    parameter logic [W-1:0] P = W'(CRC32_POLY)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    localparam int             NB       = W / 8;
    localparam int             IW       = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NB - 1);

    state_t          r_state;
    logic [7:0]      r_shift;
    logic            r_last_in;
    logic [2:0]      r_bitcnt;
    logic [IW-1:0]   r_idx;
    logic            r_clear;
    logic [7:0]      r_out_data;
    logic            r_out_valid;
    logic            r_out_last;

    logic            w_free;
    logic            w_accept;
    logic            w_crc_rst;
    logic            w_crc_en;
    logic            w_crc_d;
    logic [W-1:0]    w_q;
    logic [NB-1:0][7:0] w_fcs;

    // Output register can take a new byte when empty or draining this cycle.
    assign w_free    = !r_out_valid || out_ready;
    assign in_ready  = (r_state == ST_IDLE) && w_free;
    assign w_accept  = in_valid && in_ready;

    // CRC is preset by the global reset or by the registered end-of-frame
    // clear; clear is a flop so it never glitches from input paths.
    assign w_crc_rst = reset | r_clear;
    assign w_crc_en  = (r_state == ST_SHIFT);
    assign w_crc_d   = r_shift[r_bitcnt];

    // Complemented CRC viewed as bytes, byte 0 = least significant.
    assign w_fcs     = ~w_q;

    crc_serial #(
        .W (W),
        .P (P)
    ) u_crc (
        .clk    (clk),
        .reset  (w_crc_rst),
        .enable (w_crc_en),
        .d      (w_crc_d),
        .q      (w_q)
    );

    // Sequencer, bit/byte counters and output holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_last_in   <= 1'b0;
            r_bitcnt    <= '0;
            r_idx       <= '0;
            r_clear     <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_clear <= 1'b0;

            // Downstream handshake runs independently of the sequencer; a
            // reload below in the same cycle overrides this drop.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift     <= in_data;
                        r_last_in   <= in_last;
                        r_out_data  <= in_data;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_bitcnt    <= '0;
                        r_state     <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        if (r_last_in) begin
                            r_idx   <= '0;
                            r_state <= ST_FCS;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_FCS: begin
                    if (w_free) begin
                        r_out_data  <= w_fcs[r_idx];
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_idx == LAST_IDX);
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_clear <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_crc32_fcs_append.sv
// Self-checking bench for crc32_fcs_append: known CRC-32 vectors, stalls,
// back-to-back frames, mid-frame reset, residue and random frames checked
// against a table-driven CRC-32 model.
module tb_crc32_fcs_append;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] in_data   = 8'h00;
    logic       in_valid  = 1'b0;
    logic       in_last   = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    bit         rdy_rand   = 1'b0;
    int         stall_cnt  = 0;
    int         stall_err  = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    logic [7:0] rx_q[$];
    bit         rx_l[$];
    logic [7:0] exp_q[$];
    bit         exp_l[$];
    logic [7:0] tx_q[$];
    logic [31:0] crc_tab[256];
    int         res_base;

    always #5 clk = ~clk;

    crc32_fcs_append dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    // Downstream sink: picks out_ready for the coming edge, records bytes that
    // will be taken there, and watches stability of a stalled output.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_cnt++;
                if (!out_valid || out_data !== prev_data) stall_err++;
            end
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                rx_l.push_back(out_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Byte-at-a-time reflected CRC-32 model.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        return (c >> 8) ^ crc_tab[c[7:0] ^ b];
    endfunction

    task automatic build_table();
        for (int n = 0; n < 256; n++) begin
            logic [31:0] v = 32'(n);
            for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
            crc_tab[n] = v;
        end
    endtask

    // Expected stream for tx_q: payload bytes then ~CRC, LSB first.
    task automatic add_frame_from_tx();
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (tx_q[i]) begin
            exp_q.push_back(tx_q[i]);
            exp_l.push_back(1'b0);
            c = crc_step(c, tx_q[i]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(c[8*k +: 8]);
            exp_l.push_back(k == 3);
        end
    endtask

    task automatic load_123456789();
        tx_q.delete();
        for (int i = 0; i < 9; i++) tx_q.push_back(8'h31 + 8'(i));
    endtask

    task automatic send_frame(input bit mark_last);
        for (int i = 0; i < tx_q.size(); i++) begin
            int n = 0;
            @(negedge clk); #1;
            in_valid = 1'b1;
            in_data  = tx_q[i];
            in_last  = mark_last && (i == tx_q.size() - 1);
            while (!in_ready && n < 1000) begin
                @(negedge clk); #1;
                n++;
            end
            if (n >= 1000) begin
                n_chk++;
                $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_rx(input int n);
        int c = 0;
        while (rx_q.size() < n && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (rx_q.size() < n) begin
            n_chk++;
            $display("FAIL rx_timeout: got %0d bytes, required %0d", rx_q.size(), n);
        end
        repeat (30) @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else n_pass++;
        n_chk++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b required 0", out_last); else n_pass++;
        n_chk++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h required 00", out_data); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_check_value();
        int base = rx_q.size();
        load_123456789();
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
        exp_l.delete();
        for (int i = 0; i < 13; i++) exp_l.push_back(i == 12);
        send_frame(1'b1);
        wait_rx(base + 13);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (base + i >= rx_q.size())
                $display("FAIL check_value byte %0d: missing, required %h", i, exp_q[i]);
            else if (rx_q[base+i] !== exp_q[i] || rx_l[base+i] !== exp_l[i])
                $display("FAIL check_value byte %0d: got %h last %b, required %h last %b",
                         i, rx_q[base+i], rx_l[base+i], exp_q[i], exp_l[i]);
            else n_pass++;
        end
        n_chk++;
        if (rx_q.size() - base !== 13) $display("FAIL check_value count: got %0d required 13", rx_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_single_zero();
        int base = rx_q.size();
        int cyc;
        exp_q = '{8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk); #1;
        in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b required 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        cyc = 1;
        while (!(out_valid && out_last) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_chk++; if (cyc !== 13) $display("FAIL single_cycles: got %0d required 13", cyc); else n_pass++;
        wait_rx(base + 5);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (base + i >= rx_q.size())
                $display("FAIL single_zero byte %0d: missing, required %h", i, exp_q[i]);
            else if (rx_q[base+i] !== exp_q[i] || rx_l[base+i] !== exp_l[i])
                $display("FAIL single_zero byte %0d: got %h last %b, required %h last %b",
                         i, rx_q[base+i], rx_l[base+i], exp_q[i], exp_l[i]);
            else n_pass++;
        end
        n_chk++;
        if (rx_q.size() - base !== 5) $display("FAIL single_zero count: got %0d required 5", rx_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_stall();
        int base = rx_q.size();
        int s0 = stall_cnt;
        int e0 = stall_err;
        load_123456789();
        exp_q.delete(); exp_l.delete();
        add_frame_from_tx();
        rdy_rand = 1'b1;
        send_frame(1'b1);
        wait_rx(base + 13);
        rdy_rand = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (base + i >= rx_q.size())
                $display("FAIL stall byte %0d: missing, required %h", i, exp_q[i]);
            else if (rx_q[base+i] !== exp_q[i] || rx_l[base+i] !== exp_l[i])
                $display("FAIL stall byte %0d: got %h last %b, required %h last %b",
                         i, rx_q[base+i], rx_l[base+i], exp_q[i], exp_l[i]);
            else n_pass++;
        end
        n_chk++;
        if (rx_q.size() - base !== 13) $display("FAIL stall count: got %0d required 13", rx_q.size() - base);
        else n_pass++;
        n_chk++; if (stall_err !== e0) $display("FAIL stall_stable: got %0d unstable cycles required 0", stall_err - e0); else n_pass++;
        n_chk++; if (stall_cnt <= s0) $display("FAIL stall_seen: got %0d stall cycles required >0", stall_cnt - s0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base = rx_q.size();
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB, 8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
        exp_l.delete();
        for (int i = 0; i < 18; i++) exp_l.push_back(i == 12 || i == 17);
        load_123456789();
        send_frame(1'b1);
        tx_q = '{8'h00};
        send_frame(1'b1);
        wait_rx(base + 18);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (base + i >= rx_q.size())
                $display("FAIL back_to_back byte %0d: missing, required %h", i, exp_q[i]);
            else if (rx_q[base+i] !== exp_q[i] || rx_l[base+i] !== exp_l[i])
                $display("FAIL back_to_back byte %0d: got %h last %b, required %h last %b",
                         i, rx_q[base+i], rx_l[base+i], exp_q[i], exp_l[i]);
            else n_pass++;
        end
        n_chk++;
        if (rx_q.size() - base !== 18) $display("FAIL back_to_back count: got %0d required 18", rx_q.size() - base);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int base;
        tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        send_frame(1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid: got %b required 0", out_valid); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready: got %b required 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL midreset_next_out_valid: got %b required 0", out_valid); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL midreset_next_in_ready: got %b required 1", in_ready); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        base = rx_q.size();
        res_base = base;
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
        exp_l.delete();
        for (int i = 0; i < 13; i++) exp_l.push_back(i == 12);
        load_123456789();
        send_frame(1'b1);
        wait_rx(base + 13);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (base + i >= rx_q.size())
                $display("FAIL midreset byte %0d: missing, required %h", i, exp_q[i]);
            else if (rx_q[base+i] !== exp_q[i] || rx_l[base+i] !== exp_l[i])
                $display("FAIL midreset byte %0d: got %h last %b, required %h last %b",
                         i, rx_q[base+i], rx_l[base+i], exp_q[i], exp_l[i]);
            else n_pass++;
        end
    endtask

    task automatic test_residue();
        logic [31:0] c = 32'hFFFF_FFFF;
        int got = 0;
        for (int i = 0; i < 13 && res_base + i < rx_q.size(); i++) begin
            c = crc_step(c, rx_q[res_base+i]);
            got++;
        end
        n_chk++;
        if (got !== 13 || c !== 32'hDEBB20E3)
            $display("FAIL residue: got %h over %0d bytes, required DEBB20E3 over 13", c, got);
        else n_pass++;
    endtask

    task automatic test_random_frames();
        int base = rx_q.size();
        int e0 = stall_err;
        exp_q.delete(); exp_l.delete();
        rdy_rand = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int len = $urandom_range(1, 7);
            tx_q.delete();
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
            add_frame_from_tx();
            send_frame(1'b1);
        end
        wait_rx(base + exp_q.size());
        rdy_rand = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++;
            if (base + i >= rx_q.size())
                $display("FAIL random byte %0d: missing, required %h", i, exp_q[i]);
            else if (rx_q[base+i] !== exp_q[i] || rx_l[base+i] !== exp_l[i])
                $display("FAIL random byte %0d: got %h last %b, required %h last %b",
                         i, rx_q[base+i], rx_l[base+i], exp_q[i], exp_l[i]);
            else n_pass++;
        end
        n_chk++;
        if (rx_q.size() - base !== exp_q.size())
            $display("FAIL random count: got %0d required %0d", rx_q.size() - base, exp_q.size());
        else n_pass++;
        n_chk++; if (stall_err !== e0) $display("FAIL random_stable: got %0d unstable cycles required 0", stall_err - e0); else n_pass++;
    endtask

    initial begin
        build_table();
        test_reset();
        test_check_value();
        test_single_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_residue();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/crc32_fcs_append.md
# crc32_fcs_append

Frame check sequence generator for the transmit path. It accepts a byte stream with valid/ready/last framing and forwards each byte unchanged. Each byte is fed LSB-first, one bit per clock, into a serial CRC register. After the last payload byte it appends the complemented CRC as W/8 bytes, least-significant byte first. It sits directly upstream of the byte-to-line serializer and drives the serial CRC engine as its bit source.

## Interface
- `W`, default 32: CRC width in bits; must be a multiple of 8.
- `P`, default `'hEDB88320`: CRC polynomial, LSB-first (reversed) form.
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: reset, asynchronous, active-high.
- `in_data` input, 8 bits: payload byte.
- `in_valid` input, 1 bit: `in_data` and `in_last` are valid.
- `in_last` input, 1 bit: this byte is the final payload byte of the frame.
- `in_ready` output, 1 bit: block accepts a byte this cycle.
- `out_data` output, 8 bits: payload or FCS byte.
- `out_valid` output, 1 bit: `out_data` is valid.
- `out_last` output, 1 bit: final FCS byte of the frame.
- `out_ready` input, 1 bit: downstream accepts `out_data`.

## Operation
- States:
  - `IDLE`: waiting for a byte.
  - `SHIFT`: 8 cycles, feeding bits into the CRC.
  - `FCS`: emitting W/8 bytes.
- Output holding register: `out_data`, `out_valid`, `out_last`, single entry.
  - "Free" means `!out_valid || out_ready`.
- `in_ready` = (state == `IDLE`) && output register free.
- Accept (`in_valid && in_ready`) in `IDLE`:
  - latch the byte into the shift register and latch `in_last`;
  - load the output register with the byte, `out_last` = 0;
  - bit counter = 0;
  - go to `SHIFT`.
- `SHIFT`:
  - CRC enable = 1; CRC data bit = `shift[bitcnt]`, bit 0 first.
  - Each cycle: `q <= (q >> 1) ^ ((q[0] ^ d) ? P : 0)`.
  - After bitcnt 7: if the latched last flag is set, go to `FCS` with byte index 0; otherwise go to `IDLE`.
- `FCS`:
  - When the output register is free, load `out_data` = `~q[8i+7:8i]`.
  - `out_last` = (i == W/8-1); i increments.
  - After loading byte W/8-1: go to `IDLE` and pulse the registered `clear` for one cycle.
  - CRC enable = 0 throughout.
- CRC register initialisation: all-ones on `reset` or `clear`.
  - `clear` comes straight from a flop and never combinationally from inputs.
- Frames always contain at least one payload byte. `in_last` on the first byte gives a 1-byte frame.

## Timing
- Reset values:
  - state `IDLE`; `in_ready` = 1;
  - `out_valid` = 0, `out_last` = 0, `out_data` = 0;
  - CRC = all-ones; `clear` = 0; bitcnt = 0; byte index = 0.
- Payload byte latency: accepted at edge k, visible on `out_*` from edge k. It holds until `out_ready`.
- Throughput: at most one payload byte per 9 cycles (1 `IDLE` + 8 `SHIFT`).
- FCS byte i appears no earlier than 1 cycle after the output register frees.
- With `out_ready` held at 1, a frame of N bytes completes in 9N + W/8 cycles.
- In `SHIFT` and `FCS`, `in_ready` = 0 regardless of `out_ready`.
- In `SHIFT`, the output handshake keeps running independently. The register may empty while shifting.
- Backpressure: `out_valid` and `out_data` must stay stable while `out_valid && !out_ready`.
- Simultaneous output handshake and reload in the same cycle: the new byte replaces the old one with no bubble.
- Reset mid-frame (any state):
  - immediately abort the frame, with no FCS emitted;
  - `out_valid` drops;
  - CRC returns to all-ones.
- Next frame after `FCS`: `clear` is high in the first `IDLE` cycle. The earliest new accept occurs at the end of that cycle, so shifting never overlaps `clear`.

## Structure
- Shared package: state encoding constants and the default polynomial constants (CRC-32 `'hEDB88320`, CRC-32C `'h82F63B78`).
- Sub-module: `crc_serial`.
  - Parameters: W, P.
  - `reset` driven by `reset | clear`; `enable` = (state == `SHIFT`); `d` = current bit.
  - Its `q` is read for the FCS bytes.
- Everything else is in this block: FSM, bit counter, byte index, output register.

## Test plan
- "123456789" (0x31..0x39, last on 0x39), `out_ready` = 1 → outputs 31..39, then 26 39 F4 CB; `out_last` only on CB.
- Single byte 0x00 with last → 00, 8D EF 02 D2; cycle count 9 + 4.
- "123456789" with random `out_ready` stalls → identical byte sequence, no drops or duplicates, and `out_data` stable during stalls.
- Two back-to-back frames ("123456789", then 0x00) → both FCS values correct, confirming `clear` restored all-ones between frames.
- Assert reset during `SHIFT` of byte 5 → `out_valid` = 0 and `in_ready` = 1 next cycle; a following "123456789" frame yields 26 39 F4 CB.
- Feed the 13-byte output back through a checker CRC → register ends at residue 0xDEBB20E3.
